dmem_hs: RTL and testbench

- Parametrised data memory for the NPC core, replacing the fixed single-cycle, always-ready DRAM stub.
- Adds a valid/ready request channel and a valid/ready response channel.
- Programmable wait-state latency, byte-masked writes, and an error response for out-of-range or misaligned accesses.
- Sits between the CPU load/store unit and the top level; the CPU must stall on the handshake.

---
 rtl/dmem_hs_if.sv | 27 ++
 rtl/dmem_hs.sv | 124 ++++++++++++
 tb/tb_dmem_hs.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_hs_if.sv
// Request/response handshake bundle between the load/store unit and dmem_hs.
// master = CPU side, slave = memory side.
interface dmem_hs_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_hs.sv
// Data memory with valid/ready request and response channels, programmable
// wait states, byte-masked writes and an error response for bad addresses.
module dmem_hs #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int                LATENCY   = 2
) (
    input  logic     clk,
    input  logic     rst,
    dmem_hs_if.slave bus
);
    localparam int              BYTES  = DATA_W / 8;
    localparam int              SHIFT  = $clog2(BYTES);
    localparam int              IDX_W  = $clog2(DEPTH);
    localparam logic [3:0]      LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_cnt;
    logic                r_reqReady;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BYTES-1:0]    r_wmask;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_inIdle;
    logic                w_accept;
    logic                w_doAccess;
    logic                w_accWen;
    logic [ADDR_W-1:0]   w_accAddr;
    logic [DATA_W-1:0]   w_accWdata;
    logic [BYTES-1:0]    w_accWmask;
    logic [ADDR_W-1:0]   w_offset;
    logic [ADDR_W-1:0]   w_wordOff;
    logic [IDX_W-1:0]    w_index;
    logic                w_err;

    assign w_inIdle = (r_state == IDLE);
    assign w_accept = w_inIdle && bus.req_valid && r_reqReady;

    // With zero latency the access uses the live request; otherwise the latched copy.
    assign w_accWen   = w_inIdle ? bus.req_wen   : r_wen;
    assign w_accAddr  = w_inIdle ? bus.req_addr  : r_addr;
    assign w_accWdata = w_inIdle ? bus.req_wdata : r_wdata;
    assign w_accWmask = w_inIdle ? bus.req_wmask : r_wmask;

    assign w_doAccess = ((LATENCY == 0) && w_accept) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0));

    // Below-base check comes first so a wrapped offset can never look valid.
    assign w_offset  = w_accAddr - BASE_ADDR;
    assign w_wordOff = w_offset >> SHIFT;
    assign w_index   = w_wordOff[IDX_W-1:0];
    assign w_err     = (w_accAddr < BASE_ADDR) ||
                       (w_wordOff >= ADDR_W'(DEPTH)) ||
                       (w_accAddr[SHIFT-1:0] != '0);

    assign bus.req_ready  = r_reqReady;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd0) w_nextState = RESP;
            RESP:    if (bus.resp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Ready is registered so it stays low through reset and the handshake cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reqReady <= 1'b0;
            r_cnt      <= 4'd0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_reqReady <= (w_nextState == IDLE);
            if (w_accept) begin
                r_wen   <= bus.req_wen;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_wmask <= bus.req_wmask;
                r_cnt   <= LAT_M1;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_doAccess) begin
                r_rdata <= (!w_accWen && !w_err) ? r_mem[w_index] : '0;
                r_err   <= w_err;
            end else if ((r_state == RESP) && bus.resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_doAccess && w_accWen && !w_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_accWmask[b]) r_mem[w_index][8*b +: 8] <= w_accWdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: three builds (LATENCY 2, 4, 0) share one
// stimulus bus, selected by 'sel', and are checked against a word-map model.
module tb_dmem_hs;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        reqValid = 1'b0;
    logic        reqWen = 1'b0;
    logic        respReady = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWdata = '0;
    logic [3:0]  reqWmask = '0;

    logic        oReady [3];
    logic        oValid [3];
    logic        oErr   [3];
    logic [31:0] oRdata [3];

    int testCount = 0;
    int failCount = 0;

    logic [31:0] modelMem [longint];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gDut
            dmem_hs_if #(.ADDR_W(32), .DATA_W(32)) bus ();
            assign bus.req_valid  = reqValid && (sel == g);
            assign bus.req_wen    = reqWen;
            assign bus.req_addr   = reqAddr;
            assign bus.req_wdata  = reqWdata;
            assign bus.req_wmask  = reqWmask;
            assign bus.resp_ready = respReady && (sel == g);
            assign oReady[g] = bus.req_ready;
            assign oValid[g] = bus.resp_valid;
            assign oRdata[g] = bus.resp_rdata;
            assign oErr[g]   = bus.resp_err;
            dmem_hs #(
                .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                .LATENCY((g == 0) ? 2 : ((g == 1) ? 4 : 0))
            ) u_dut (
                .clk(clk),
                .rst(rst),
                .bus(bus)
            );
        end
    endgenerate

    function automatic int latOf(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 4 : 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word-addressed reference: error rules evaluated on plain unsigned arithmetic.
    task automatic modelAccess(input int s, input logic wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask,
                               output logic [31:0] expData, output logic expErr);
        longint      a;
        longint      key;
        logic [31:0] word;
        a = longint'(addr);
        expData = 32'h0;
        expErr = (a < longint'(BASE)) || ((a % 4) != 0) ||
                 (((a - longint'(BASE)) / 4) >= DEPTH);
        if (!expErr) begin
            key = longint'(s) * 1048576 + (a - longint'(BASE)) / 4;
            word = modelMem.exists(key) ? modelMem[key] : 32'h0;
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) word[8*b +: 8] = wdata[8*b +: 8];
                modelMem[key] = word;
            end else begin
                expData = word;
            end
        end
    endtask

    task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input int hold);
        logic [31:0] expData;
        logic        expErr;
        int          lat;
        int          waitC;
        lat = latOf(sel);
        waitC = 0;
        @(negedge clk);
        while (!oReady[sel] && waitC < 50) begin
            @(negedge clk);
            waitC++;
        end
        checkOutput("req_ready_before_accept", 32'(oReady[sel]), 32'd1);
        reqValid = 1'b1;
        reqWen   = wen;
        reqAddr  = addr;
        reqWdata = wdata;
        reqWmask = mask;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqAddr  = $urandom;
        reqWdata = $urandom;
        modelAccess(sel, wen, addr, wdata, mask, expData, expErr);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            checkOutput("resp_valid_timing", 32'(oValid[sel]), 32'(k == lat));
            checkOutput("req_ready_busy", 32'(oReady[sel]), 32'd0);
        end
        checkOutput("resp_rdata", oRdata[sel], expData);
        checkOutput("resp_err", 32'(oErr[sel]), 32'(expErr));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 32'(oValid[sel]), 32'd1);
            checkOutput("hold_rdata", oRdata[sel], expData);
            checkOutput("hold_err", 32'(oErr[sel]), 32'(expErr));
            checkOutput("hold_ready", 32'(oReady[sel]), 32'd0);
        end
        respReady = 1'b1;
        @(posedge clk);
        #1;
        respReady = 1'b0;
        checkOutput("post_hs_valid", 32'(oValid[sel]), 32'd0);
        checkOutput("post_hs_ready", 32'(oReady[sel]), 32'd1);
        checkOutput("post_hs_rdata", oRdata[sel], 32'd0);
        checkOutput("post_hs_err", 32'(oErr[sel]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] expData;
        logic        expErr;
        logic [31:0] a;
        int          respCount;
        int          r;

        #2 rst = 1'b0;
        #10;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("reset_req_ready", 32'(oReady[s]), 32'd0);
            checkOutput("reset_resp_valid", 32'(oValid[s]), 32'd0);
            checkOutput("reset_resp_rdata", oRdata[s], 32'd0);
            checkOutput("reset_resp_err", 32'(oErr[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // LATENCY=2 build: directed cases.
        sel = 0;
        applyStimulus(1'b1, BASE, 32'hDEADBEEF, 4'hF, 0);
        applyStimulus(1'b0, BASE, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, BASE, 32'h11223344, 4'b0101, 0);
        applyStimulus(1'b0, BASE, 32'h0, 4'h0, 0);
        applyStimulus(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0);
        applyStimulus(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 0);
        applyStimulus(1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 4'hF, 0);
        applyStimulus(1'b0, BASE, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, BASE + 32'h4, 32'h0, 4'h0, 0);
        applyStimulus(1'b0, BASE, 32'h0, 4'h0, 10);

        // LATENCY=2 build: randomized traffic over a 16-word window.
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0);
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (r == 1)
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 8))
                                                : BASE + 32'(4 * (DEPTH + $urandom_range(0, 8)));
            else
                a = BASE + 32'(4 * $urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        // LATENCY=0 build: preload then stream 8 back-to-back reads.
        sel = 2;
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, 0);
        respCount = 0;
        reqWen    = 1'b0;
        reqAddr   = BASE + 32'h100;
        reqValid  = 1'b1;
        respReady = 1'b1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk);
            #1;
            if (oValid[2]) respCount++;
            if (e % 2 == 0) begin
                modelAccess(2, 1'b0, BASE + 32'h100 + 32'(4 * (e / 2)), 32'h0, 4'h0, expData, expErr);
                checkOutput("stream_valid", 32'(oValid[2]), 32'd1);
                checkOutput("stream_rdata", oRdata[2], expData);
                checkOutput("stream_err", 32'(oErr[2]), 32'(expErr));
                if (e / 2 < 7) reqAddr = BASE + 32'h100 + 32'(4 * (e / 2 + 1));
                else           reqValid = 1'b0;
            end else begin
                checkOutput("stream_gap_valid", 32'(oValid[2]), 32'd0);
                checkOutput("stream_gap_ready", 32'(oReady[2]), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        if (oValid[2]) respCount++;
        respReady = 1'b0;
        checkOutput("stream_resp_count", 32'(respCount), 32'd8);

        // LATENCY=4 build: reset pulse while a write sits in WAIT.
        sel = 1;
        applyStimulus(1'b1, BASE + 32'h40, 32'h0, 4'hF, 0);
        reqValid = 1'b1;
        reqWen   = 1'b1;
        reqAddr  = BASE + 32'h40;
        reqWdata = 32'hCAFEBABE;
        reqWmask = 4'hF;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("wait_valid", 32'(oValid[1]), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midreset_req_ready", 32'(oReady[1]), 32'd0);
        checkOutput("midreset_resp_valid", 32'(oValid[1]), 32'd0);
        checkOutput("midreset_resp_rdata", oRdata[1], 32'd0);
        checkOutput("midreset_resp_err", 32'(oErr[1]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checkOutput("after_reset_no_resp", 32'(oValid[1]), 32'd0);
        end
        applyStimulus(1'b0, BASE + 32'h40, 32'h0, 4'h0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
